// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: BLANK/SHOW time multiplexing with a
// double-buffered load/ready handshake. Optional blinking under DISP_BLINK_EN.
module seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [19:0] digits_in,
  input  logic [3:0]  blink_mask,
  output logic        ready,
  output logic [4:0]  code,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int MAX_CYC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SHOW_PRE   = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0][4:0] active_q, active_d;
  logic [19:0]     pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [3:0]      an_q, an_d;
  logic [4:0]      code_q, code_d;
  logic            frame_done_q, frame_done_d;
  logic            ready_q, ready_d;
  logic            boundary_s;
  logic [3:0]      blink_s;

  // Phase sequencing, digit index, and the pending/active buffer swap.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    boundary_s   = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d    = ST_BLANK;
          cnt_d      = {CW{1'b0}};
          idx_d      = idx_q + 2'd1;
          boundary_s = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = {CW{1'b0}};
      end
    endcase
    // A load can only be accepted while pend is empty, so it never races the swap.
    if (boundary_s && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
    end else if (load && !pend_valid_q) begin
      pend_d       = digits_in;
      pend_valid_d = 1'b1;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_phase_q, blink_phase_d;

  // Frame counter toggling the blink phase every BLINK_FRAMES boundaries.
  always_comb begin
    fcnt_d        = fcnt_q;
    blink_phase_d = blink_phase_q;
    if (boundary_s) begin
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d        = {FW{1'b0}};
        blink_phase_d = ~blink_phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end else begin
      fcnt_d = fcnt_q;
    end
    blink_s = blink_phase_d ? blink_mask : 4'b0000;
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q        <= {FW{1'b0}};
      blink_phase_q <= 1'b0;
    end else begin
      fcnt_q        <= fcnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = ^blink_mask;
  assign blink_s        = 4'b0000;
`endif

  // Outputs are computed from next state so the registers line up with state_q.
  always_comb begin
    if (state_d == ST_SHOW) begin
      an_d = ~(4'b0001 << idx_d) | blink_s;
    end else begin
      an_d = 4'b1111;
    end
    code_d       = active_d[idx_d];
    frame_done_d = (state_q == ST_SHOW) && (idx_q == 2'd3) && (cnt_q == SHOW_PRE);
    ready_d      = ~pend_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= {CW{1'b0}};
      idx_q        <= 2'd0;
      active_q     <= 20'd0;
      pend_q       <= 20'd0;
      pend_valid_q <= 1'b0;
      an_q         <= 4'b1111;
      code_q       <= 5'd0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      code_q       <= code_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
    end
  end

  assign an         = an_q;
  assign code       = code_q;
  assign frame_done = frame_done_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYC=2, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [19:0] digits_in;
  logic [3:0]  blink_mask;
  logic        ready;
  logic [4:0]  code;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int n = 0;

  localparam logic [19:0] DATA_A = 20'h88421; // {17,1,1,1}
  localparam logic [19:0] DATA_B = 20'hFFFFF; // {31,31,31,31}
  localparam logic [19:0] DATA_C = 20'h10C85; // {2,3,4,5}

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blink_mask(blink_mask), .ready(ready), .code(code), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h, expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected an/code/frame_done for sample n of a 24-cycle frame.
  task automatic chk_view(input logic [19:0] shown);
    int p, d, q;
    logic [3:0] an_exp;
    logic [4:0] code_exp;
    p = n % 24;
    d = p / 6;
    q = p % 6;
    an_exp = 4'b0001 << d;
    an_exp = ~an_exp;
    if (q < 2) an_exp = 4'b1111;
`ifdef DISP_BLINK_EN
    if (q >= 2 && ((n / 24) / 2) % 2 == 1) an_exp = an_exp | blink_mask;
`endif
    code_exp = shown[d*5 +: 5];
    check_eq("an", 32'(an), 32'(an_exp));
    check_eq("code", 32'(code), 32'(code_exp));
    check_eq("frame_done", 32'(frame_done), 32'(p == 23));
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    digits_in = 20'd0;
    blink_mask = 4'b0000;
    #12;
    check_eq("rst_an", 32'(an), 32'(4'b1111));
    check_eq("rst_code", 32'(code), 32'(5'd0));
    check_eq("rst_ready", 32'(ready), 32'(1'b1));
    check_eq("rst_frame_done", 32'(frame_done), 32'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    for (int i = 0; i < 48; i++) begin
      chk_view(20'd0);
      if (n == 0 || n == 23) check_eq("idle_ready", 32'(ready), 32'(1'b1));
      tick();
    end

    // Frame 2: load mid digit 1, then a second load while busy.
    for (int i = 0; i < 24; i++) begin
      chk_view(20'd0);
      if (n == 56) begin
        load = 1'b1;
        digits_in = DATA_A;
      end else if (n == 57) begin
        check_eq("ready_drop", 32'(ready), 32'(1'b0));
        digits_in = DATA_B;
      end else if (n == 58) begin
        load = 1'b0;
      end else if (n == 71) begin
        check_eq("ready_hold", 32'(ready), 32'(1'b0));
      end
      tick();
    end

    // Frame 3 shows A; load C exactly on the frame_done cycle.
    for (int i = 0; i < 24; i++) begin
      chk_view(DATA_A);
      if (n == 72) check_eq("ready_rise", 32'(ready), 32'(1'b1));
      if (n == 95) begin
        load = 1'b1;
        digits_in = DATA_C;
      end
      tick();
    end

    for (int i = 0; i < 24; i++) begin
      chk_view(DATA_A);
      if (n == 96) begin
        check_eq("ready_fd_load", 32'(ready), 32'(1'b0));
        load = 1'b0;
      end
      tick();
    end

    for (int i = 0; i < 24; i++) begin
      chk_view(DATA_C);
      if (n == 120) check_eq("ready_rise2", 32'(ready), 32'(1'b1));
      tick();
    end

    // Frame 6: queue A, then reset during digit 2 SHOW.
    for (int i = 0; i < 16; i++) begin
      chk_view(DATA_C);
      if (n == 144) begin
        load = 1'b1;
        digits_in = DATA_A;
      end else if (n == 145) begin
        load = 1'b0;
        check_eq("ready_pend", 32'(ready), 32'(1'b0));
      end
      tick();
    end
    check_eq("pre_rst_an", 32'(an), 32'(4'b1011));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_an", 32'(an), 32'(4'b1111));
    check_eq("mid_rst_ready", 32'(ready), 32'(1'b1));
    check_eq("mid_rst_code", 32'(code), 32'(5'd0));
    blink_mask = 4'b0100;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;

    for (int i = 0; i < 144; i++) begin
      chk_view(20'd0);
      if (n == 24) check_eq("post_rst_ready", 32'(ready), 32'(1'b1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It holds four 5-bit display codes: 0–9 digits, plus letter codes 14–24 in the team's code table. It cycles through the digits, driving the shared 5-bit code bus into the BCDToLED decoder and the active-low anode enables. Each digit change is separated by a blanking interval to suppress ghosting. New values arrive over a load/ready handshake and are double-buffered, so a frame never shows a mix of old and new digits.

## Interface
- `CLK_DIV`, default 100000: clock cycles each digit is lit (SHOW length); must be ≥ 2.
- `BLANK_CYC`, default 16: clock cycles all anodes are off before each digit (BLANK length); must be ≥ 1.
- `BLINK_FRAMES`, default 64: frames per blink half-period; used only with `DISP_BLINK_EN`; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `load`  in  1  request to accept `digits_in`; sampled only while `ready`=1.
- `digits_in`  in  20  four codes; digit0=[4:0], digit1=[9:5], digit2=[14:10], digit3=[19:15].
- `blink_mask`  in  4  per-digit blink enable; bit i applies to digit i.
- `ready`  out  1  pending buffer is free; a load is accepted this cycle.
- `code`  out  5  code of the current digit; connects to the BCDToLED `x` input.
- `an`  out  4  anode enables, active-low; `an[i]`=0 lights digit i.
- `frame_done`  out  1  one-cycle pulse at the end of digit 3's SHOW.

## Operation
- Storage:
  - `active[0..3]`: displayed codes.
  - `pend[0..3]` plus `pend_valid`: pending buffer.
  - 2-bit digit index `idx`.
  - Phase counter, width $clog2(max(CLK_DIV, BLANK_CYC)).
- FSM states are BLANK and SHOW.
  - BLANK: `an`=4'b1111, `code`=`active[idx]`. After `BLANK_CYC` cycles, go to SHOW.
  - SHOW: `an`=~(4'b0001<<idx), `code`=`active[idx]`. After `CLK_DIV` cycles, go to BLANK and set `idx`=`idx`+1, wrapping 3→0.
- `code` changes only while in BLANK, never while an anode is low.
- Frame boundary is the last SHOW cycle with `idx`=3. On that cycle:
  - `frame_done`=1.
  - If `pend_valid`, then `active`<=`pend` and `pend_valid`<=0 on the same edge.
- Handshake:
  - `ready`=~`pend_valid`.
  - `load`&`ready` captures `digits_in` into `pend` and sets `pend_valid`.
  - `load` while `ready`=0 is ignored; nothing is queued and no error is flagged.
- Simultaneous events:
  - Load accepted on a boundary cycle while `pend_valid`=0: captured into `pend` and applied at the next boundary.
  - Boundary while `pend_valid`=1: `active` takes the old `pend`, and `ready` rises the following cycle.
- Code values are passed through unchecked. Codes 10–13 and 25–31 produce whatever the decoder produces.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - Outputs: `an`=4'b1111, `code`=5'd0, `ready`=1, `frame_done`=0.
  - State: BLANK, `idx`=0, phase counter=0, `active`=`pend`=all 0, `pend_valid`=0, blink phase=0.
- After reset release:
  - First SHOW of digit 0 starts after `BLANK_CYC` cycles.
  - Frame length is 4·(`CLK_DIV`+`BLANK_CYC`) cycles.
- Load-to-display latency:
  - `ready` falls one cycle after acceptance.
  - New codes appear in `code` in the BLANK that follows the next boundary. Worst case is one frame plus `BLANK_CYC`.
- Reset mid-frame: all of the above return immediately; the pending load is discarded.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Configuration
- `DISP_BLINK_EN`, when defined:
  - A frame counter toggles `blink_phase` every `BLINK_FRAMES` frame boundaries.
  - While `blink_phase`=1, SHOW keeps `an[idx]`=1 for any digit with `blink_mask[idx]`=1.
  - FSM timing and `code` are unchanged.
- When undefined: no frame counter and no phase register; `blink_mask` is ignored.

## Test plan
Directed scenarios use `CLK_DIV`=4, `BLANK_CYC`=2, `BLINK_FRAMES`=2.
- Reset then run: `an` goes 1111 ×2, 1110 ×4, 1111 ×2, 1101 ×4, …, 0111 ×4, with `code`=0 throughout. `frame_done` pulses every 24 cycles.
- Load 20'h8_8421, i.e. codes {17,1,1,1}, mid digit 1:
  - `ready` drops next cycle.
  - `code` stays 0 until the boundary.
  - After the boundary, digit 0 shows 1 and digit 3 shows 17.
  - `ready` is back to 1 one cycle after the boundary.
- Second load while `ready`=0 with different data: ignored; the first data is displayed.
- Load asserted exactly on the `frame_done` cycle with `ready`=1: not displayed in the next frame, displayed in the frame after.
- `rst_n` pulsed low during digit 2 SHOW with a load pending: `an`=1111 and `ready`=1 immediately; after release, display shows 0000.
- With `DISP_BLINK_EN` and `blink_mask`=4'b0100: frames 0–1 light all four digits; frames 2–3 never drive `an[2]` low; frames 4–5 light all digits again.
